// File: rtl/sum_diff_pkg.sv
// Shared types and width helpers for the bit-serial sum-difference select evaluator.
// Pure declarations: no logic, no latency, no flow control.
package sum_diff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_W = 8;

  // Three W-bit terms plus the borrow of the subtraction need three extra bits.
  function automatic int calc_rw(input int w);
    return w + 3;
  endfunction

  function automatic int calc_cw(input int w);
    return $clog2(calc_rw(w));
  endfunction

endpackage

// File: rtl/serial_fa.sv
// One-bit serial full adder: combinational sum, carry registered for the next bit.
// Carry advances only when en is high; preset reloads CARRY_INIT. No flow control.
module serial_fa #(
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic preset,
  input  logic x,
  input  logic y,
  output logic s
);

  logic carry_q;

  assign s = x ^ y ^ carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= CARRY_INIT;
    end else if (preset) begin
      carry_q <= CARRY_INIT;
    end else if (en) begin
      carry_q <= (x & y) | (x & carry_q) | (y & carry_q);
    end
  end

endmodule

// File: rtl/serial_sum_diff_eval.sv
// Bit-serial a+b+c-d with select f = result!=0 ? e : 0; result valid RW cycles after accept.
// One word in flight; in_ready low until the result is taken, result/f held for any out_ready stall.
module serial_sum_diff_eval
  import sum_diff_pkg::*;
#(
  parameter int  W  = DEF_W,
  localparam int RW = calc_rw(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  input  logic [W-1:0]  e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] result,
  output logic [W-1:0]  f,
  output logic          busy
);

  localparam int             CW       = calc_cw(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RW - 1);

  state_t state, state_nxt;

  logic [RW-1:0] a_sr, b_sr, c_sr, d_sr;
  logic [RW-1:0] res_next;
  logic [W-1:0]  e_q;
  logic [CW-1:0] cnt;
  logic          accept, shift_en, cnt_last;
  logic          s1, s2, r_bit;

  assign accept   = in_valid && (state == IDLE);
  assign shift_en = (state == SHIFT);
  assign cnt_last = shift_en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)             state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST)      state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // s1 = a+b, s2 = c-d (as c + ~d + 1), r = s1 + s2; carries run LSB first.
  serial_fa #(.CARRY_INIT(1'b0)) u_fa_ab (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (shift_en),
    .preset (accept),
    .x      (a_sr[0]),
    .y      (b_sr[0]),
    .s      (s1)
  );

  serial_fa #(.CARRY_INIT(1'b1)) u_fa_cd (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (shift_en),
    .preset (accept),
    .x      (c_sr[0]),
    .y      (~d_sr[0]),
    .s      (s2)
  );

  serial_fa #(.CARRY_INIT(1'b0)) u_fa_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (shift_en),
    .preset (accept),
    .x      (s1),
    .y      (s2),
    .s      (r_bit)
  );

  // New bit enters at the MSB; after RW shifts the first bit sits at position 0.
  assign res_next = {r_bit, result[RW-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      c_sr   <= '0;
      d_sr   <= '0;
      e_q    <= '0;
      cnt    <= '0;
      result <= '0;
      f      <= '0;
    end else if (accept) begin
      a_sr <= {{(RW-W){1'b0}}, a};
      b_sr <= {{(RW-W){1'b0}}, b};
      c_sr <= {{(RW-W){1'b0}}, c};
      d_sr <= {{(RW-W){1'b0}}, d};
      e_q  <= e;
      cnt  <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      c_sr   <= c_sr >> 1;
      d_sr   <= d_sr >> 1;
      cnt    <= cnt + 1'b1;
      result <= res_next;
      // f is decided from the completed word so it is valid together with out_valid.
      if (cnt_last) begin
        f <= (res_next != '0) ? e_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_sum_diff_eval.sv
// Directed, table-driven bench for serial_sum_diff_eval (W=8, RW=11).
// Covers reset values, latency, signed results, stalls, ignored inputs and mid-shift reset.
module tb_serial_sum_diff_eval;

  localparam int W  = 8;
  localparam int RW = 11;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b, c, d, e;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic [W-1:0]  f;
  logic          busy;

  int checks;
  int errors;

  serial_sum_diff_eval #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .f         (f),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a, b, c, d, e;
    logic [RW-1:0] res;
    logic [W-1:0]  f;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Handshake one word in; returns 1 time unit after the accepting edge.
  task automatic start(input logic [W-1:0] ia, ib, ic, id, ie);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    a = ia; b = ib; c = ic; d = id; e = ie;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands to show they were captured at acceptance.
    a = 8'h5C; b = 8'hE1; c = 8'h37; d = 8'h9A; e = 8'h66;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_in_shift", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(input string name, input logic [RW-1:0] er,
                           input logic [W-1:0] ef, input int already);
    int cyc;
    cyc = already;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, RW);
    chk({name, "_result"}, {21'd0, result}, {21'd0, er});
    chk({name, "_f"}, {24'd0, f}, {24'd0, ef});
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic release_out(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [RW-1:0] held_res;
    logic [W-1:0]  held_f;

    checks = 0;
    errors = 0;

    vecs[0] = '{a:8'd3,   b:8'd4,   c:8'd10,  d:8'd2,   e:8'hA5, res:11'd15,   f:8'hA5};
    vecs[1] = '{a:8'd0,   b:8'd0,   c:8'd0,   d:8'd0,   e:8'hFF, res:11'd0,    f:8'h00};
    vecs[2] = '{a:8'd0,   b:8'd0,   c:8'd0,   d:8'd255, e:8'h01, res:11'h701,  f:8'h01};
    vecs[3] = '{a:8'd255, b:8'd255, c:8'd255, d:8'd0,   e:8'h5A, res:11'h2FD,  f:8'h5A};
    vecs[4] = '{a:8'd100, b:8'd0,   c:8'd0,   d:8'd100, e:8'h77, res:11'd0,    f:8'h00};
    vecs[5] = '{a:8'd0,   b:8'd1,   c:8'd0,   d:8'd255, e:8'hC3, res:11'h702,  f:8'hC3};
    vecs[6] = '{a:8'd200, b:8'd50,  c:8'd7,   d:8'd1,   e:8'h3C, res:11'h100,  f:8'h3C};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {21'd0, result}, 32'd0);
    chk("rst_f", {24'd0, f}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e);
      wait_done($sformatf("vec%0d", i), vecs[i].res, vecs[i].f, 0);
      release_out($sformatf("vec%0d", i));
    end

    // Long out_ready stall, with in_valid pulses during SHIFT and DONE.
    start(8'd1, 8'd2, 8'd3, 8'd1, 8'h11);
    a = 8'd50; b = 8'd50; c = 8'd50; d = 8'd0; e = 8'hEE;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done("stall", 11'd5, 8'h11, 1);
    held_res = result;
    held_f   = f;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) in_valid = 1'b1;
      if (k == 8) in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("stall_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall_result_%0d", k), {21'd0, result}, {21'd0, held_res});
      chk($sformatf("stall_f_%0d", k), {24'd0, f}, {24'd0, held_f});
    end
    release_out("stall");
    start(8'd20, 8'd30, 8'd0, 8'd60, 8'h99);
    wait_done("after_stall", 11'h7F6, 8'h99, 0);
    release_out("after_stall");

    // Reset in the middle of SHIFT: everything back to reset values, no result pulse.
    start(8'd9, 8'd9, 8'd9, 8'd9, 8'h42);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", {21'd0, result}, 32'd0);
    chk("midrst_f", {24'd0, f}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst_no_valid_%0d", k), {31'd0, out_valid}, 32'd0);
    end
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    start(8'd9, 8'd9, 8'd9, 8'd9, 8'h42);
    wait_done("postrst", 11'd18, 8'h42, 0);
    release_out("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sum_diff_eval.md
Name: serial_sum_diff_eval

Overview:
- Sequential, bit-serial evaluator of the team's sum-difference select function: f = ((a+b)+(c-d)) != 0 ? e : 0.
- Implements the same function as our combinational version, but on W-bit words, processed one bit per cycle, LSB first.
- Operands are taken in through a valid/ready handshake. The signed result and the gated select are returned through a second valid/ready handshake.
- Sits between an operand producer and any consumer that needs the evaluated select, where area matters more than latency.

Parameters:
- W, 8, operand width in bits (W >= 2).
- RW, W+3, result width. Derived; not overridable. Holds the full signed range -(2^W-1) .. 3*(2^W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept operands.
- a  in  W  unsigned operand.
- b  in  W  unsigned operand.
- c  in  W  unsigned operand.
- d  in  W  unsigned operand (subtracted).
- e  in  W  select data, captured with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  RW  two's-complement value of a+b+c-d.
- f  out  W  captured e if result != 0, else 0.
- busy  out  1  high in SHIFT state.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, f=0. State=IDLE, bit counter=0, all carry registers at their init values, operand shift registers=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: capture a, b, c, d into RW-bit shift registers, zero-extended. Capture e.
  - At that edge, clear the counter, preset the carries, and go to SHIFT.
- SHIFT:
  - in_ready=0. in_valid is ignored.
  - Each cycle, process bit i = counter.
  - Serial adder 1: s1 = a_i + b_i, carry init 0.
  - Serial adder 2: s2 = c_i + ~d_i, carry init 1. The zero-extended d is inverted, so its upper bits are 1s.
  - Serial adder 3: r_i = s1 + s2, carry init 0.
  - r_i shifts into the result register from the MSB side, so after RW cycles bit 0 is in place.
  - The counter runs from 0 to RW-1. On counter==RW-1, go to DONE.
  - The final carries are discarded (modulo 2^RW).
- DONE:
  - out_valid=1 from edge T+RW. result is stable.
  - f = (result != 0) ? e_captured : 0, registered on entry to DONE.
  - result and f are held unchanged while out_ready=0, for any length of stall.
  - On out_valid&&out_ready: go to IDLE. out_valid=0 and in_ready=1 from the next cycle.
  - No same-cycle turnaround. Minimum spacing between input acceptances is RW+2 cycles.
- in_valid while not in IDLE: no effect and no error. The producer must hold the operands until in_ready.
- rst_n low at any point, including mid-SHIFT or in DONE: immediate return to the reset values. The partial result is lost and no out_valid pulse occurs.
- Operands changing during SHIFT have no effect, because they are captured at acceptance.
- Edge cases: result=0 forces f=0 even when e != 0. d > a+b+c gives a negative result in two's complement.

Decomposition:
- Package sum_diff_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Function computing RW from W.
  - Counter width constant: $clog2(RW).
- Sub-module serial_fa:
  - One-bit full adder with a registered carry.
  - Parameter CARRY_INIT, with a synchronous preset input and the async rst_n.
  - Instantiated three times.

Test Plan (W=8, RW=11):
- a=3, b=4, c=10, d=2, e=8'hA5 accepted at T → out_valid at T+11, result=11'd15, f=8'hA5.
- a=b=c=d=0, e=8'hFF → result=0, f=8'h00.
- a=b=c=0, d=255, e=8'h01 → result=11'h701 (-255), f=8'h01.
- a=b=c=255, d=0 → result=11'h2FD (765), with no overflow.
- out_ready held low 20 cycles:
  - result and f remain stable throughout.
  - in_valid pulsed with new operands during SHIFT and DONE is ignored.
  - After out_ready rises, the next operands are accepted and produce the correct result.
- rst_n asserted at cycle 5 of SHIFT → all outputs return to their reset values asynchronously; in_ready=1 after release. A subsequent transaction then gives the correct result.
